// File: rtl/rms_div_issue_if.sv
// Handshake/data bundle between a vector source, an RMS source and the divider pipe
// feeding logic.
//   in_data/in_valid/in_ready    : vector element stream (dividends)
//   rms_data/rms_valid/rms_ready : one divisor per vector
//   out_a/out_b/out_valid        : operand pair towards the divider (no backpressure)
//   done                         : one-cycle pulse after a vector has been fully issued
//   div_zero                     : latched divisor is +/-0
// The slave modport is the issuing block; the master modport is its environment.
interface rms_div_issue_if #(
  parameter int unsigned DW = 32
) ();
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] rms_data;
  logic          rms_valid;
  logic          rms_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic          out_valid;
  logic          done;
  logic          div_zero;

  modport master (
    output in_data, in_valid, rms_data, rms_valid,
    input  in_ready, rms_ready, out_a, out_b, out_valid, done, div_zero
  );

  modport slave (
    input  in_data, in_valid, rms_data, rms_valid,
    output in_ready, rms_ready, out_a, out_b, out_valid, done, div_zero
  );
endinterface

// File: rtl/rms_div_issue.sv
// Buffers one vector of VEC_LEN floating-point elements, waits for its RMS divisor, then
// issues VEC_LEN back-to-back (element, rms) pairs to a divider pipe. Data is moved
// bit-exact; the only inspection of a value is the +/-0 test on the divisor.
// Ports:
//   clk : clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : rms_div_issue_if slave modport (element/rms inputs, divider operands, status)
module rms_div_issue #(
  parameter int unsigned SIG_WIDTH = 23,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned VEC_LEN   = 16
) (
  input  logic           clk,
  input  logic           rst,
  rms_div_issue_if.slave bus
);
  localparam int unsigned DW    = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int unsigned IDX_W = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {StLoad, StWaitRms, StIssue, StDone} state_e;

  state_e state_q, state_d;

  logic [DW-1:0]    vec_buf_q [VEC_LEN];
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             rms_held_q;
  logic [DW-1:0]    rms_reg_q;
  logic [DW-1:0]    out_a_q;
  logic [DW-1:0]    out_b_q;
  logic             out_valid_q;
  logic             done_q;
  logic             div_zero_q;

  logic in_ready;
  logic rms_ready;
  logic in_xfer;
  logic rms_xfer;
  logic wr_last;
  logic rd_last;
  logic rms_is_zero;

  // Zero test ignores the sign bit so both +0 and -0 flag.
  assign rms_is_zero = (bus.rms_data[DW-2:0] == '0);
  assign wr_last     = (wr_idx_q == LastIdx);
  assign rd_last     = (rd_idx_q == LastIdx);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad: begin
        if (in_xfer && wr_last) begin
          // A divisor arriving on the same edge as the last element counts as held.
          state_d = (rms_held_q || rms_xfer) ? StIssue : StWaitRms;
        end
      end
      StWaitRms: begin
        if (rms_xfer) state_d = StIssue;
      end
      StIssue: begin
        if (rd_last) state_d = StDone;
      end
      StDone: state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == StLoad);
    rms_ready = ((state_q == StLoad) || (state_q == StWaitRms)) && !rms_held_q;
    in_xfer   = bus.in_valid && in_ready;
    rms_xfer  = bus.rms_valid && rms_ready;
  end

  // Element buffer; not reset, a partially loaded vector is simply overwritten.
  always_ff @(posedge clk) begin
    if (in_xfer) vec_buf_q[wr_idx_q] <= bus.in_data;
  end

  // Indices, divisor latch and registered divider operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      rms_held_q  <= 1'b0;
      rms_reg_q   <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (in_xfer) begin
        wr_idx_q <= wr_last ? '0 : wr_idx_q + IDX_W'(1);
      end
      if (rms_xfer) begin
        rms_reg_q  <= bus.rms_data;
        rms_held_q <= 1'b1;
        div_zero_q <= rms_is_zero;
      end
      case (state_q)
        StIssue: begin
          out_a_q     <= vec_buf_q[rd_idx_q];
          out_b_q     <= rms_reg_q;
          out_valid_q <= 1'b1;
          rd_idx_q    <= rd_last ? '0 : rd_idx_q + IDX_W'(1);
        end
        StDone: begin
          out_valid_q <= 1'b0;
          done_q      <= 1'b1;
          rms_held_q  <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rms_ready = rms_ready;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
endmodule
